ro_window_counter: RTL and testbench

- Parametrised, multi-channel successor to the single 16-bit RO edge counter.
- Counts per-channel RO edge enables (CE) over a fixed, programmable measurement window.
- At window end, latches all counts, raises a one-cycle DONE pulse and produces a PUF response bit from comparing channel 0 against channel 1.
- Sits between the RO/edge-synchroniser array and the response-collection logic.

---
 rtl/ro_window_counter.sv | 174 +++++++++++++++++
 tb/tb_ro_window_counter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ro_window_counter.sv
// -----------------------------------------------------------------------------
// ro_window_counter
//
// Multi-channel ring-oscillator edge counter. After a START, each channel counts
// its edge-enable pulses over a fixed window of WINDOW clock cycles. At the end
// of the window the counts, the saturation flags and a PUF response bit
// (channel 0 count > channel 1 count) are latched, and DONE pulses for one cycle.
//
// Parameters
//   WIDTH   bits per channel counter (counters saturate at 2^WIDTH-1)
//   N_CH    number of RO channels (>= 1)
//   WINDOW  measurement window length in clock cycles (>= 1)
//
// Ports
//   i_clk    system clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   i_start  begin a measurement (sampled only in IDLE)
//   i_clr    synchronous abort/clear, active-high, highest priority
//   i_ce     per-channel count enable, already synchronous to i_clk
//   o_busy   high while the window is running
//   o_done   one-cycle pulse when the latched result is valid
//   o_count  latched counts, channel i at [i*WIDTH +: WIDTH]
//   o_sat    latched per-channel saturation flags
//   o_resp   latched response, 1 iff count0 > count1 (0 on tie or N_CH==1)
//
// State    | meaning
// ---------+----------------------------------------------------------------
// S_IDLE   | waiting for START; outputs hold the last latched result
// S_RUN    | window open; CE counted every cycle, timer advancing
// S_DONE   | single cycle; result just latched, DONE asserted
// -----------------------------------------------------------------------------
module ro_window_counter #(
    parameter int WIDTH  = 16,
    parameter int N_CH   = 2,
    parameter int WINDOW = 16384
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic                    i_clr,
    input  logic [N_CH-1:0]         i_ce,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [N_CH*WIDTH-1:0]   o_count,
    output logic [N_CH-1:0]         o_sat,
    output logic                    o_resp
);

    // Timer reaches WINDOW on the final RUN edge, so it needs room for WINDOW.
    localparam int              TW         = $clog2(WINDOW + 1);
    localparam logic [WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [TW-1:0]    TIMER_LAST = TW'(WINDOW - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [TW-1:0]           r_timer;
    logic [N_CH*WIDTH-1:0]   r_cnt;
    logic [N_CH-1:0]         r_sat_int;

    logic [N_CH*WIDTH-1:0]   r_count;
    logic [N_CH-1:0]         r_sat;
    logic                    r_resp;

    logic [N_CH*WIDTH-1:0]   w_cnt_inc;
    logic [N_CH-1:0]         w_sat_inc;
    logic                    w_resp_nxt;
    logic                    w_last;

    assign w_last = (r_timer == TIMER_LAST);

    // Per-channel saturating increment; a CE arriving at full scale sets the
    // sticky saturation flag instead of wrapping.
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [WIDTH-1:0] w_cur;
        logic             w_at_max;

        assign w_cur    = r_cnt[g*WIDTH +: WIDTH];
        assign w_at_max = (w_cur == CNT_MAX);

        assign w_cnt_inc[g*WIDTH +: WIDTH] =
            (i_ce[g] && !w_at_max) ? (w_cur + 1'b1) : w_cur;
        assign w_sat_inc[g] = r_sat_int[g] | (i_ce[g] & w_at_max);
    end

    // Response uses the counts including the final window cycle's CE, since it
    // is latched on the same edge as that last increment.
    if (N_CH >= 2) begin : g_resp
        assign w_resp_nxt = (w_cnt_inc[0 +: WIDTH] > w_cnt_inc[WIDTH +: WIDTH]);
    end else begin : g_no_resp
        assign w_resp_nxt = 1'b0;
    end

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last)  w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (i_clr) begin
            w_state_nxt = S_IDLE;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath: window timer, channel counters and latched result
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_timer   <= '0;
            r_cnt     <= '0;
            r_sat_int <= '0;
            r_count   <= '0;
            r_sat     <= '0;
            r_resp    <= 1'b0;
        end else if (i_clr) begin
            r_timer   <= '0;
            r_cnt     <= '0;
            r_sat_int <= '0;
            r_count   <= '0;
            r_sat     <= '0;
            r_resp    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_timer   <= '0;
                        r_cnt     <= '0;
                        r_sat_int <= '0;
                    end
                end
                S_RUN: begin
                    r_timer   <= r_timer + 1'b1;
                    r_cnt     <= w_cnt_inc;
                    r_sat_int <= w_sat_inc;
                    if (w_last) begin
                        r_count <= w_cnt_inc;
                        r_sat   <= w_sat_inc;
                        r_resp  <= w_resp_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // All outputs come straight from registers.
    assign o_busy  = (r_state == S_RUN);
    assign o_done  = (r_state == S_DONE);
    assign o_count = r_count;
    assign o_sat   = r_sat;
    assign o_resp  = r_resp;

endmodule

// File: tb/tb_ro_window_counter.sv
module tb_ro_window_counter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        clr;

    // Instance A: WIDTH=16, N_CH=2, WINDOW=16
    logic        start_a;
    logic [1:0]  ce_a;
    logic        busy_a, done_a, resp_a;
    logic [31:0] count_a;
    logic [1:0]  sat_a;

    // Instance B: WIDTH=4, N_CH=2, WINDOW=20 (saturation)
    logic        start_b;
    logic [1:0]  ce_b;
    logic        busy_b, done_b, resp_b;
    logic [7:0]  count_b;
    logic [1:0]  sat_b;

    int total = 0;
    int bad   = 0;

    ro_window_counter #(.WIDTH(16), .N_CH(2), .WINDOW(16)) u_dut_a (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start_a),
        .i_clr   (clr),
        .i_ce    (ce_a),
        .o_busy  (busy_a),
        .o_done  (done_a),
        .o_count (count_a),
        .o_sat   (sat_a),
        .o_resp  (resp_a)
    );

    ro_window_counter #(.WIDTH(4), .N_CH(2), .WINDOW(20)) u_dut_b (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start_b),
        .i_clr   (clr),
        .i_ce    (ce_b),
        .o_busy  (busy_b),
        .o_done  (done_b),
        .o_count (count_b),
        .o_sat   (sat_b),
        .o_resp  (resp_b)
    );

    typedef struct {
        logic [15:0] p0;    // CE[0] pattern, bit n-1 = cycle n of the window
        logic [15:0] p1;    // CE[1] pattern
        logic [15:0] e0;    // expected count ch0
        logic [15:0] e1;    // expected count ch1
        logic        er;    // expected response
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Runs one window on instance A. Called at #1 after an edge with the DUT
    // in IDLE; returns at #1 into the IDLE cycle following DONE.
    task automatic measure(input logic [15:0] p0, input logic [15:0] p1,
                           input logic [15:0] e0, input logic [15:0] e1,
                           input logic er, input logic hold_start);
        start_a = 1'b1;
        ce_a    = 2'b00;
        @(posedge clk); #1;
        if (!hold_start) start_a = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            ce_a = {p1[n-1], p0[n-1]};
            chk("busy_in_run", busy_a, 1);
            chk("done_in_run", done_a, 0);
            @(posedge clk); #1;
        end
        ce_a = 2'b00;
        chk("done_pulse", done_a, 1);
        chk("busy_in_done", busy_a, 0);
        chk("count_ch0", count_a[15:0], e0);
        chk("count_ch1", count_a[31:16], e1);
        chk("sat", sat_a, 0);
        chk("resp", resp_a, er);
        @(posedge clk); #1;
        start_a = 1'b0;
        chk("done_cleared", done_a, 0);
        chk("busy_idle", busy_a, 0);
        chk("count_hold", count_a, {e1, e0});
    endtask

    initial begin
        vecs[0] = '{16'hFFFF, 16'h5555, 16'd16, 16'd8,  1'b1};
        vecs[1] = '{16'h5555, 16'h5555, 16'd8,  16'd8,  1'b0};
        vecs[2] = '{16'h000F, 16'h0FFF, 16'd4,  16'd12, 1'b0};
        vecs[3] = '{16'h0000, 16'h0000, 16'd0,  16'd0,  1'b0};
        vecs[4] = '{16'h00FF, 16'h0007, 16'd8,  16'd3,  1'b1};
        vecs[5] = '{16'h8001, 16'h0001, 16'd2,  16'd1,  1'b1};
        vecs[6] = '{16'h0001, 16'h8000, 16'd1,  16'd1,  1'b0};

        rst_n   = 1'b0;
        clr     = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        ce_a    = 2'b00;
        ce_b    = 2'b00;
        #12;
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_count", count_a, 0);
        chk("rst_sat", sat_a, 0);
        chk("rst_resp", resp_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven windows
        for (int v = 0; v < 7; v++) begin
            measure(vecs[v].p0, vecs[v].p1, vecs[v].e0, vecs[v].e1, vecs[v].er, 1'b0);
        end

        // CLR at cycle t+5 of a RUN (result from last vector is 1/1)
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        ce_a    = 2'b11;
        for (int n = 1; n <= 4; n++) begin
            @(posedge clk); #1;
        end
        clr = 1'b1;
        @(posedge clk); #1;
        clr  = 1'b0;
        ce_a = 2'b00;
        chk("clr_busy", busy_a, 0);
        chk("clr_done", done_a, 0);
        chk("clr_count", count_a, 0);
        chk("clr_sat", sat_a, 0);
        chk("clr_resp", resp_a, 0);
        begin
            logic seen;
            seen = 1'b0;
            for (int n = 0; n < 20; n++) begin
                if (done_a || busy_a) seen = 1'b1;
                @(posedge clk); #1;
            end
            chk("clr_no_done", seen, 0);
        end
        measure(vecs[0].p0, vecs[0].p1, vecs[0].e0, vecs[0].e1, vecs[0].er, 1'b0);

        // Asynchronous reset mid-RUN (latched result is 16/8, resp=1)
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        ce_a    = 2'b11;
        for (int n = 1; n <= 3; n++) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy_a, 0);
        chk("arst_done", done_a, 0);
        chk("arst_count", count_a, 0);
        chk("arst_resp", resp_a, 0);
        ce_a = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_stays_idle", busy_a, 0);
        measure(vecs[4].p0, vecs[4].p1, vecs[4].e0, vecs[4].e1, vecs[4].er, 1'b0);

        // START held through RUN and DONE, then a back-to-back window
        measure(vecs[2].p0, vecs[2].p1, vecs[2].e0, vecs[2].e1, vecs[2].er, 1'b1);
        measure(vecs[0].p0, vecs[0].p1, vecs[0].e0, vecs[0].e1, vecs[0].er, 1'b0);

        // Saturation on instance B: WIDTH=4, WINDOW=20, CE=11
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        ce_b    = 2'b11;
        for (int n = 1; n <= 20; n++) begin
            chk("sat_busy_in_run", busy_b, 1);
            chk("sat_done_in_run", done_b, 0);
            @(posedge clk); #1;
        end
        ce_b = 2'b00;
        chk("sat_done_pulse", done_b, 1);
        chk("sat_count", count_b, 8'hFF);
        chk("sat_flags", sat_b, 2'b11);
        chk("sat_resp_tie", resp_b, 0);
        @(posedge clk); #1;
        chk("sat_done_cleared", done_b, 0);
        chk("sat_flags_hold", sat_b, 2'b11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
